signal_serializer: RTL and testbench

Framing serializer that sits directly upstream of `network`: it accepts parallel `DATA_WIDTH` samples, such as the 8-bit words loaded from the stimulus sample files, and drives them onto the single-bit `d` line that `network` samples. It buffers samples in a small FIFO. Each sample goes out as a start bit, the data bits LSB first, and a stop bit, with a programmable number of clock cycles per bit. Frames run back-to-back while samples are queued.

---
 rtl/wardriver_pkg.sv | 14 +
 rtl/sample_fifo.sv | 42 ++++
 rtl/signal_serializer.sv | 118 +++++++++++
 tb/tb_signal_serializer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/wardriver_pkg.sv
// Shared types and defaults for the serial stimulus path.
package wardriver_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ser_state_t;

  // Default sample width, shared with the stimulus bench.
  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample buffer. Pointers carry one extra MSB so full and empty
// can be told apart when the index bits match.
module sample_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  // Pointer advance; overflow and underflow requests are dropped here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)  wptr <= wptr + 1'b1;
      if (pop  && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/signal_serializer.sv
// Framing serializer: buffers parallel samples and sends each as
// start(0), data LSB first, stop(1), every bit held BIT_CYCLES clocks.
// The line register d follows the FSM state by one cycle.
module signal_serializer
  import wardriver_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  d,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  ser_state_t            state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shift, fifo_q;
  logic                  full, empty, push, pop, bit_end;

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign bit_end  = (cnt == CNT_LAST);
  assign busy     = (state != IDLE);

  sample_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .wdata(in_data),
    .push (push),
    .pop  (pop),
    .rdata(fifo_q),
    .full (full),
    .empty(empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, pop request and end-of-frame pulse.
  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = START;
        end
      end
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && idx == IDX_LAST) state_nxt = STOP;
      STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing counter, bit index and data shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else if (pop) begin
      shift <= fifo_q;
      cnt   <= '0;
      idx   <= '0;
    end else if (state != IDLE) begin
      cnt <= bit_end ? '0 : cnt + 1'b1;
      if (state == DATA && bit_end) begin
        shift <= shift >> 1;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Registered line driver, idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d <= 1'b1;
    end else begin
      case (state)
        START:   d <= 1'b0;
        DATA:    d <= shift[0];
        default: d <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_signal_serializer.sv
// Directed bench for signal_serializer: one instance with BIT_CYCLES=1,
// one with BIT_CYCLES=3, sharing clock and reset.
module tb_signal_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data1, in_data3;
  logic       in_valid1, in_valid3;
  logic       in_ready1, d1, busy1, fd1;
  logic       in_ready3, d3, busy3, fd3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  signal_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .d(d1), .busy(busy1), .frame_done(fd1)
  );

  signal_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .d(d3), .busy(busy3), .frame_done(fd3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Receiver for dut1: at the frame_done cycle d shows data bit 7,
  // the previous seven samples hold bits 6..0.
  logic [9:0] hist;
  logic [7:0] rx_q[$];
  always @(negedge clk) begin
    if (fd1) rx_q.push_back({d1, hist[9:3]});
    hist <= {d1, hist[9:1]};
  end

  // Check nfr back-to-back frames on dut1, starting at the start-bit sample.
  task automatic watch1(input string tag, input int nfr, input logic [7:0] b0, input logic [7:0] b1);
    logic [9:0] fr;
    for (int i = 0; i < 10 * nfr; i++) begin
      fr = {1'b1, (i < 10) ? b0 : b1, 1'b0};
      chk({tag, "_d"},    32'(d1),    32'(fr[i % 10]));
      chk({tag, "_fd"},   32'(fd1),   32'((i % 10) == 8));
      chk({tag, "_busy"}, 32'(busy1), 32'(i != 10 * nfr - 1));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    logic was_rdy;
    logic [9:0] fr3;

    in_valid1 = 1'b0; in_data1 = 8'h00;
    in_valid3 = 1'b0; in_data3 = 8'h00;

    // Reset held 3 cycles with a sample offered.
    rst = 1'b1; in_valid1 = 1'b1; in_data1 = 8'h55;
    tick(); tick(); tick();
    chk("rst_d",     32'(d1),        32'd1);
    chk("rst_busy",  32'(busy1),     32'd0);
    chk("rst_rdy",   32'(in_ready1), 32'd1);
    chk("rst_fd",    32'(fd1),       32'd0);
    rst = 1'b0; in_valid1 = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rst_noq_busy", 32'(busy1), 32'd0);
    chk("rst_noq_d",    32'(d1),    32'd1);

    // Single frame 8'hA5: d = 0,1,0,1,0,0,1,0,1,1.
    rx_q.delete();
    in_valid1 = 1'b1; in_data1 = 8'hA5;
    tick();
    in_valid1 = 1'b0;
    tick();
    chk("a5_pre_d",    32'(d1),    32'd1);
    chk("a5_pre_busy", 32'(busy1), 32'd1);
    tick();
    watch1("a5", 1, 8'hA5, 8'h00);
    chk("a5_rx", 32'(rx_q.size() == 1 ? rx_q[0] : 8'hxx), 32'hA5);

    // Back-to-back frames 00 then FF.
    in_valid1 = 1'b1; in_data1 = 8'h00;
    tick();
    in_data1 = 8'hFF;
    tick();
    in_valid1 = 1'b0;
    tick();
    watch1("b2b", 2, 8'h00, 8'hFF);

    // Full FIFO: one sample popped, four queued, then in_ready drops.
    rx_q.delete();
    acc = 0; in_valid1 = 1'b1; in_data1 = 8'h01;
    for (int c = 0; c < 8; c++) begin
      was_rdy = in_ready1;
      tick();
      if (was_rdy) begin
        acc++;
        in_data1 = 8'(acc + 1);
      end
    end
    chk("full_rdy", 32'(in_ready1), 32'd0);
    chk("full_acc", 32'(acc),       32'd5);
    in_valid1 = 1'b0;
    for (int k = 0; k < 100 && rx_q.size() < 5; k++) tick();
    chk("full_cnt", 32'(rx_q.size()), 32'd5);
    for (int j = 0; j < rx_q.size() && j < 5; j++)
      chk("full_ord", 32'(rx_q[j]), 32'(j + 1));
    for (int k = 0; k < 30; k++) tick();
    chk("full_nodup", 32'(rx_q.size()), 32'd5);
    chk("full_idle",  32'(busy1),       32'd0);

    // Bit stretching on dut3: 8'h81 over 30 cycles.
    in_valid3 = 1'b1; in_data3 = 8'h81;
    tick();
    in_valid3 = 1'b0;
    tick(); tick();
    fr3 = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 30; i++) begin
      chk("bc3_d",    32'(d3),    32'(fr3[i / 3]));
      chk("bc3_fd",   32'(fd3),   32'(i == 28));
      chk("bc3_busy", 32'(busy3), 32'(i != 29));
      tick();
    end

    // Mid-frame reset during data bit 4 of 8'h3C, AA and BB still queued.
    rx_q.delete();
    in_valid1 = 1'b1; in_data1 = 8'h3C;
    tick();
    in_data1 = 8'hAA;
    tick();
    in_data1 = 8'hBB;
    tick();
    in_valid1 = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    chk("mid_pre_busy", 32'(busy1), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_d",    32'(d1),        32'd1);
    chk("mid_rst_busy", 32'(busy1),     32'd0);
    chk("mid_rst_rdy",  32'(in_ready1), 32'd1);
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    chk("mid_noframe", 32'(rx_q.size()), 32'd0);
    chk("mid_busy",    32'(busy1),       32'd0);
    chk("mid_d",       32'(d1),          32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
